wb_rr_intercon: RTL and testbench

Parametrised shared-bus Wishbone interconnect joining up to 4 masters to up to 8 slaves. Round-robin arbitration, mask/base address decoding, and bus-error generation for unmapped addresses and stalled slaves. It replaces the fixed 8x8 priority interconnect in the SoC top levels. The LM32 instruction and data ports and any future DMA master attach to it directly.

---
 rtl/wb_rr_intercon_if.sv | 34 +++
 rtl/wb_rr_intercon.sv | 106 ++++++++++
 tb/tb_wb_rr_intercon.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_intercon_if.sv
// wb_rr_intercon_if: master-side and slave-side Wishbone signal bundle of the shared-bus interconnect
interface wb_rr_intercon_if #(
    parameter int num_masters = 2,
    parameter int num_slaves = 8
);
    logic [num_masters*32-1:0] m_adr_i;
    logic [num_masters*32-1:0] m_dat_i;
    logic [num_masters*4-1:0] m_sel_i;
    logic [num_masters-1:0] m_we_i;
    logic [num_masters-1:0] m_cyc_i;
    logic [num_masters-1:0] m_stb_i;
    logic [31:0] m_dat_o;
    logic [num_masters-1:0] m_ack_o;
    logic [num_masters-1:0] m_err_o;
    logic [num_masters-1:0] m_rty_o;
    logic [31:0] s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0] s_sel_o;
    logic s_we_o;
    logic [num_slaves-1:0] s_cyc_o;
    logic [num_slaves-1:0] s_stb_o;
    logic [num_slaves*32-1:0] s_dat_i;
    logic [num_slaves-1:0] s_ack_i;
    logic [num_slaves-1:0] s_err_i;
    logic [num_slaves-1:0] s_rty_i;
    modport slave (
        input m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );
    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input m_dat_o, m_ack_o, m_err_o, m_rty_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
    );
endinterface

// File: rtl/wb_rr_intercon.sv
// wb_rr_intercon: round-robin shared-bus Wishbone interconnect with mask/base decode and bus-error generation
module wb_rr_intercon #(
    parameter int num_masters = 2,
    parameter int num_slaves = 8,
    parameter logic [num_slaves*32-1:0] slave_base = '0,
    parameter logic [num_slaves*32-1:0] slave_mask = '0,
    parameter int timeout = 255
) (
    input logic clk,
    input logic reset,
    wb_rr_intercon_if.slave bus
);
    logic gnt_valid, err_r, any_req, act, own_cyc, own_stb, hit, term, stall, fire;
    logic [1:0] owner, last, winner, mi;
    logic [2:0] sel;
    logic [7:0] tmo_cnt, match, ack_p, err_p, rty_p, cyc8, stb8;
    logic [3:0] cyc_p, stb_p, we_p, ack4, err4, rty4;
    logic [15:0] sel_p;
    logic [127:0] adr_p, dat_p;
    logic [255:0] sdat_p;
    logic [31:0] adr;

    // Pad the per-port vectors to the maximum widths so a 2-bit owner / 3-bit select can index them directly
    assign cyc_p = 4'(bus.m_cyc_i);
    assign stb_p = 4'(bus.m_stb_i);
    assign we_p = 4'(bus.m_we_i);
    assign sel_p = 16'(bus.m_sel_i);
    assign adr_p = 128'(bus.m_adr_i);
    assign dat_p = 128'(bus.m_dat_i);
    assign sdat_p = 256'(bus.s_dat_i);
    assign ack_p = 8'(bus.s_ack_i);
    assign err_p = 8'(bus.s_err_i);
    assign rty_p = 8'(bus.s_rty_i);

    // Nearest requester after last wins; scanning farthest-first lets the nearest overwrite
    always_comb begin
        winner = '0;
        any_req = 1'b0;
        for (int i = num_masters; i >= 1; i--)
            if (cyc_p[2'((int'(last) + i) % num_masters)]) begin
                winner = 2'((int'(last) + i) % num_masters);
                any_req = 1'b1;
            end
    end

    assign mi = gnt_valid ? owner : 2'd0;
    assign adr = adr_p[{mi, 5'd0} +: 32];

    always_comb begin
        match = '0;
        sel = '0;
        for (int k = 0; k < num_slaves; k++)
            match[k] = (adr & slave_mask[k*32 +: 32]) == (slave_base[k*32 +: 32] & slave_mask[k*32 +: 32]);
        for (int k = num_slaves - 1; k >= 0; k--)
            if (match[k]) sel = 3'(k);
    end

    assign hit = |match;
    assign act = gnt_valid & ~reset;
    assign own_cyc = act & cyc_p[owner];
    assign own_stb = own_cyc & stb_p[owner];
    assign cyc8 = (own_cyc & hit) ? 8'd1 << sel : '0;
    assign stb8 = (own_stb & hit) ? 8'd1 << sel : '0;
    assign term = ack_p[sel] | err_p[sel] | rty_p[sel];
    assign stall = own_stb & hit & ~term;
    assign fire = timeout != 0 && stall && tmo_cnt == 8'(timeout);

    always_comb begin
        ack4 = '0;
        err4 = '0;
        rty4 = '0;
        ack4[owner] = act & hit & ack_p[sel];
        rty4[owner] = act & hit & rty_p[sel];
        err4[owner] = ~reset & ((act & hit & err_p[sel]) | err_r);
    end

    assign bus.s_adr_o = adr;
    assign bus.s_dat_o = dat_p[{mi, 5'd0} +: 32];
    assign bus.s_sel_o = sel_p[{mi, 2'd0} +: 4];
    assign bus.s_we_o = we_p[mi];
    assign bus.s_cyc_o = cyc8[num_slaves-1:0];
    assign bus.s_stb_o = stb8[num_slaves-1:0];
    assign bus.m_dat_o = hit ? sdat_p[{sel, 5'd0} +: 32] : '0;
    assign bus.m_ack_o = ack4[num_masters-1:0];
    assign bus.m_err_o = err4[num_masters-1:0];
    assign bus.m_rty_o = rty4[num_masters-1:0];

    always_ff @(posedge clk)
        if (reset) begin
            gnt_valid <= 1'b0;
            owner <= '0;
            last <= 2'(num_masters - 1);
            err_r <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            err_r <= (own_stb & ~hit & ~err_r) | fire;
            tmo_cnt <= (timeout != 0 && stall && !fire) ? tmo_cnt + 8'd1 : '0;
            if (~gnt_valid | ~cyc_p[owner]) begin
                gnt_valid <= any_req;
                if (any_req) begin
                    owner <= winner;
                    last <= winner;
                end
            end
        end
endmodule

// File: tb/tb_wb_rr_intercon.sv
// tb_wb_rr_intercon: directed vectors plus a per-cycle reference model of arbitration, decode and error rules
module tb_wb_rr_intercon;
    localparam int NM = 2;
    localparam int NS = 8;
    localparam int TMO = 4;
    localparam logic [255:0] SB = {32'h8000_0000, 32'h7000_0000, 32'h6000_0000, 32'h5000_0000,
                                   32'h3000_0000, 32'h0000_0000, 32'h4000_0010, 32'h4000_0000};
    localparam logic [255:0] SM = {{4{32'hF000_0000}}, 32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_FFF0, 32'hFFFF_0000};
    localparam int WAIT [8] = '{0, 0, 2, 1000, 0, 0, 0, 0};
    localparam logic [7:0] RTYM = 8'b0001_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    wb_rr_intercon_if #(.num_masters(NM), .num_slaves(NS)) bus ();

    wb_rr_intercon #(
        .num_masters(NM), .num_slaves(NS), .slave_base(SB), .slave_mask(SM), .timeout(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Simple slaves: terminate after WAIT[k] strobed cycles, slave 4 answers with retry
    int wcnt [8] = '{default: 0};
    always_ff @(posedge clk)
        for (int k = 0; k < 8; k++)
            wcnt[k] <= (bus.s_stb_o[k] && !(bus.s_ack_i[k] || bus.s_rty_i[k])) ? wcnt[k] + 1 : 0;
    always_comb begin
        bus.s_ack_i = '0;
        bus.s_rty_i = '0;
        bus.s_err_i = '0;
        bus.s_dat_i = '0;
        for (int k = 0; k < 8; k++) begin
            bus.s_dat_i[k*32 +: 32] = 32'hD000_0000 + 32'(k);
            bus.s_ack_i[k] = bus.s_stb_o[k] && wcnt[k] == WAIT[k] && !RTYM[k];
            bus.s_rty_i[k] = bus.s_stb_o[k] && wcnt[k] == WAIT[k] && RTYM[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int k = 0; k < NS; k++)
            if ((a & SM[k*32 +: 32]) == (SB[k*32 +: 32] & SM[k*32 +: 32])) return k;
        return -1;
    endfunction

    // Reference model: owner = -1 means no grant; err_owner is whoever last held the grant
    int md_owner = -1, md_reg = 0, md_last = NM - 1, md_cnt = 0;
    bit md_err = 1'b0;
    int n_owner = -1, n_reg = 0, n_last = NM - 1, n_cnt = 0;
    bit n_err = 1'b0;

    always @(posedge clk) begin
        md_owner <= n_owner;
        md_reg <= n_reg;
        md_last <= n_last;
        md_cnt <= n_cnt;
        md_err <= n_err;
    end

    always @(negedge clk) begin
        int o, sk, c;
        bit gv, cyc_o, stb_o, term, stall, fire;
        logic [7:0] ecyc, estb;
        logic [1:0] eack, eerr, erty;
        gv = md_owner >= 0;
        o = gv ? md_owner : 0;
        sk = decode(bus.m_adr_i[o*32 +: 32]);
        cyc_o = gv && !reset && bus.m_cyc_i[o];
        stb_o = cyc_o && bus.m_stb_i[o];
        ecyc = (cyc_o && sk >= 0) ? 8'(1 << sk) : 8'd0;
        estb = (stb_o && sk >= 0) ? 8'(1 << sk) : 8'd0;
        eack = '0;
        erty = '0;
        eerr = '0;
        if (gv && !reset && sk >= 0 && bus.s_ack_i[sk]) eack[o] = 1'b1;
        if (gv && !reset && sk >= 0 && bus.s_rty_i[sk]) erty[o] = 1'b1;
        if (!reset && (md_err || (gv && sk >= 0 && bus.s_err_i[sk]))) eerr[md_reg] = 1'b1;
        chk("s_cyc", 32'(bus.s_cyc_o), 32'(ecyc));
        chk("s_stb", 32'(bus.s_stb_o), 32'(estb));
        chk("s_adr", bus.s_adr_o, bus.m_adr_i[o*32 +: 32]);
        chk("s_dat", bus.s_dat_o, bus.m_dat_i[o*32 +: 32]);
        chk("s_sel", 32'(bus.s_sel_o), 32'(bus.m_sel_i[o*4 +: 4]));
        chk("s_we", 32'(bus.s_we_o), 32'(bus.m_we_i[o]));
        chk("m_dat", bus.m_dat_o, sk >= 0 ? bus.s_dat_i[sk*32 +: 32] : 32'd0);
        chk("m_ack", 32'(bus.m_ack_o), 32'(eack));
        chk("m_rty", 32'(bus.m_rty_o), 32'(erty));
        chk("m_err", 32'(bus.m_err_o), 32'(eerr));
        if (reset) begin
            n_owner = -1;
            n_reg = 0;
            n_last = NM - 1;
            n_cnt = 0;
            n_err = 1'b0;
        end else begin
            term = sk >= 0 && (bus.s_ack_i[sk] || bus.s_err_i[sk] || bus.s_rty_i[sk]);
            stall = stb_o && sk >= 0 && !term;
            fire = TMO != 0 && stall && md_cnt == TMO;
            n_err = (stb_o && sk < 0 && !md_err) || fire;
            n_cnt = (TMO != 0 && stall && !fire) ? md_cnt + 1 : 0;
            n_owner = md_owner;
            n_reg = md_reg;
            n_last = md_last;
            if (!gv || !bus.m_cyc_i[o]) begin
                n_owner = -1;
                for (int i = 1; i <= NM; i++) begin
                    c = (md_last + i) % NM;
                    if (n_owner < 0 && bus.m_cyc_i[c]) n_owner = c;
                end
                if (n_owner >= 0) begin
                    n_last = n_owner;
                    n_reg = n_owner;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic mset(input int m, input bit cyc, input bit we, input logic [31:0] adr, input logic [31:0] dat);
        bus.m_cyc_i[m] = cyc;
        bus.m_stb_i[m] = cyc;
        bus.m_we_i[m] = we;
        bus.m_sel_i[m*4 +: 4] = cyc ? 4'hF : 4'h0;
        bus.m_adr_i[m*32 +: 32] = adr;
        bus.m_dat_i[m*32 +: 32] = dat;
    endtask

    initial begin
        mset(0, 0, 0, 0, 0);
        mset(1, 0, 0, 0, 0);
        tick();
        tick();
        mid();
        chk("rst_cyc", 32'(bus.s_cyc_o), 0);
        chk("rst_stb", 32'(bus.s_stb_o), 0);
        chk("rst_term", 32'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 0);
        // master 0 reads slave 2 with two wait states
        tick();
        reset = 1'b0;
        mset(0, 1, 0, 32'h0000_1000, 0);
        mid();
        chk("rd_c0_stb", 32'(bus.s_stb_o), 0);
        tick();
        mid();
        chk("rd_c1_stb", 32'(bus.s_stb_o), 32'(8'b0000_0100));
        chk("rd_c1_ack", 32'(bus.m_ack_o), 0);
        tick();
        mid();
        chk("rd_c2_ack", 32'(bus.m_ack_o), 0);
        tick();
        mid();
        chk("rd_c3_ack", 32'(bus.m_ack_o), 32'(2'b01));
        chk("rd_c3_dat", bus.m_dat_o, 32'hD000_0002);
        tick();
        mset(0, 0, 0, 0, 0);
        // master 1 writes an unmapped address
        tick();
        mset(1, 1, 1, 32'h9000_0000, 32'h1234_5678);
        tick();
        mid();
        chk("um_c1_stb", 32'(bus.s_stb_o), 0);
        chk("um_c1_err", 32'(bus.m_err_o), 0);
        tick();
        mid();
        chk("um_c2_err", 32'(bus.m_err_o), 32'(2'b10));
        chk("um_c2_ack", 32'(bus.m_ack_o), 0);
        tick();
        mset(1, 0, 0, 0, 0);
        mid();
        chk("um_c3_err", 32'(bus.m_err_o), 0);
        // simultaneous requests with last=1: 0, then 1, then 0 again
        tick();
        mset(0, 1, 0, 32'h6000_0000, 0);
        mset(1, 1, 0, 32'h7000_0000, 0);
        tick();
        mid();
        chk("rr_d1_stb", 32'(bus.s_stb_o), 32'(8'b0010_0000));
        chk("rr_d1_ack", 32'(bus.m_ack_o), 32'(2'b01));
        tick();
        mset(0, 0, 0, 0, 0);
        tick();
        mid();
        chk("rr_d3_stb", 32'(bus.s_stb_o), 32'(8'b0100_0000));
        chk("rr_d3_ack", 32'(bus.m_ack_o), 32'(2'b10));
        tick();
        mset(1, 0, 0, 0, 0);
        tick();
        mset(0, 1, 0, 32'h6000_0000, 0);
        mset(1, 1, 0, 32'h7000_0000, 0);
        tick();
        mid();
        chk("rr_d6_stb", 32'(bus.s_stb_o), 32'(8'b0010_0000));
        tick();
        mset(0, 0, 0, 0, 0);
        mset(1, 0, 0, 0, 0);
        // overlapping slaves 0 and 1: lowest index wins
        tick();
        mset(0, 1, 0, 32'h4000_0010, 0);
        tick();
        mid();
        chk("ov_stb", 32'(bus.s_stb_o), 32'(8'b0000_0001));
        chk("ov_dat", bus.m_dat_o, 32'hD000_0000);
        tick();
        mset(0, 0, 0, 0, 0);
        // slave 3 never terminates: error 5 cycles after first strobe, then again 5 later
        tick();
        mset(0, 1, 0, 32'h3000_0000, 0);
        for (int e = 1; e <= 11; e++) begin
            tick();
            mid();
            chk("tmo_err", 32'(bus.m_err_o), (e == 6 || e == 11) ? 32'd1 : 32'd0);
            if (e == 6) chk("tmo_stb", 32'(bus.s_stb_o), 32'(8'b0000_1000));
        end
        tick();
        mset(0, 0, 0, 0, 0);
        // retry pass-through from slave 4
        tick();
        mset(1, 1, 0, 32'h5000_0000, 0);
        tick();
        mid();
        chk("rty_rty", 32'(bus.m_rty_o), 32'(2'b10));
        chk("rty_ack", 32'(bus.m_ack_o), 0);
        tick();
        mset(1, 0, 0, 0, 0);
        // reset while master 1 is mid-transfer
        tick();
        mset(1, 1, 0, 32'h3000_0000, 0);
        tick();
        mid();
        chk("mr_f1_cyc", 32'(bus.s_cyc_o), 32'(8'b0000_1000));
        tick();
        reset = 1'b1;
        mid();
        chk("mr_f2_cyc", 32'(bus.s_cyc_o), 0);
        chk("mr_f2_term", 32'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 0);
        tick();
        reset = 1'b0;
        mset(0, 1, 0, 32'h6000_0000, 0);
        mid();
        chk("mr_f3_cyc", 32'(bus.s_cyc_o), 0);
        chk("mr_f3_term", 32'({bus.m_ack_o, bus.m_err_o, bus.m_rty_o}), 0);
        tick();
        mid();
        chk("mr_f4_stb", 32'(bus.s_stb_o), 32'(8'b0010_0000));
        chk("mr_f4_ack", 32'(bus.m_ack_o), 32'(2'b01));
        tick();
        mset(0, 0, 0, 0, 0);
        mset(1, 0, 0, 0, 0);
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
